// File: rtl/mci_wdt_chain.sv
// mci_wdt_chain: parametrised multi-stage watchdog.
//   NUM_STAGES stall-free up-counters of TIMER_W bits. Each counter is compared
//   against a programmable period. In cascade mode, stage i runs only after
//   stage i-1 has expired. In independent mode, every stage runs on its own enable.
//
// Optional feature macro: MCI_WDT_PAUSE_EN
//   When defined, this adds input wdt_pause. While wdt_pause is high, no stage
//   counts. Restarts still take effect during a pause.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   stage_en        per-stage count enable (level)
//   stage_restart   per-stage restart pulse; in cascade mode it also clears all later stages
//   cascade_mode    1 = cascade, 0 = independent
//   wdt_pause       (MCI_WDT_PAUSE_EN only) global count hold
//   timeout_period  per-stage period; stage i is at [i*TIMER_W +: TIMER_W]
//   stage_count     per-stage counter, same packing as timeout_period
//   stage_expired   sticky per-stage expiry status
//   stage_timeout   one-cycle pulse when a stage expires
//   wdt_fatal       sticky; set when the last stage expires in cascade mode
module mci_wdt_chain #(
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned TIMER_W    = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_STAGES-1:0]         stage_en,
  input  logic [NUM_STAGES-1:0]         stage_restart,
  input  logic                          cascade_mode,
`ifdef MCI_WDT_PAUSE_EN
  input  logic                          wdt_pause,
`endif
  input  logic [NUM_STAGES*TIMER_W-1:0] timeout_period,
  output logic [NUM_STAGES*TIMER_W-1:0] stage_count,
  output logic [NUM_STAGES-1:0]         stage_expired,
  output logic [NUM_STAGES-1:0]         stage_timeout,
  output logic                          wdt_fatal
);

  logic [TIMER_W-1:0]    count_q [NUM_STAGES];
  logic [TIMER_W-1:0]    count_d [NUM_STAGES];
  logic [NUM_STAGES-1:0] expired_q, expired_d;
  logic [NUM_STAGES-1:0] timeout_q, timeout_d;
  logic                  fatal_q, fatal_d;
  logic [NUM_STAGES-1:0] chain_ok;
  logic [NUM_STAGES-1:0] clear;
  logic [NUM_STAGES-1:0] counting;
  logic                  upstream_restart;
  logic                  run_ok;

`ifdef MCI_WDT_PAUSE_EN
  assign run_ok = ~wdt_pause;
`else
  assign run_ok = 1'b1;
`endif

  // chain_ok[i] tells whether stage i's predecessor has expired.
  // Stage 0 has no predecessor, so chain_ok[0] is always 1.
  always_comb begin
    chain_ok    = '0;
    chain_ok[0] = 1'b1;
    for (int unsigned i = 1; i < NUM_STAGES; i++) begin
      chain_ok[i] = expired_q[i-1];
    end
  end

  always_comb begin
    clear            = '0;
    counting         = '0;
    expired_d        = expired_q;
    timeout_d        = '0;
    upstream_restart = 1'b0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      count_d[i] = count_q[i];
      // In cascade mode, a restart on any earlier stage also clears this stage.
      clear[i]         = stage_restart[i] | (cascade_mode & upstream_restart);
      upstream_restart = upstream_restart | stage_restart[i];
      counting[i]      = stage_en[i] & ~expired_q[i] & run_ok &
                         (~cascade_mode | chain_ok[i]);
      if (clear[i]) begin
        // A restart has priority over an expiry on the same edge.
        count_d[i]   = '0;
        expired_d[i] = 1'b0;
      end else if (counting[i]) begin
        if (count_q[i] >= timeout_period[i*TIMER_W +: TIMER_W]) begin
          expired_d[i] = 1'b1;
          timeout_d[i] = 1'b1;
        end else begin
          count_d[i] = count_q[i] + 1'b1;
        end
      end
    end
    fatal_d = fatal_q | (cascade_mode & timeout_d[NUM_STAGES-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        count_q[i] <= '0;
      end
      expired_q <= '0;
      timeout_q <= '0;
      fatal_q   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        count_q[i] <= count_d[i];
      end
      expired_q <= expired_d;
      timeout_q <= timeout_d;
      fatal_q   <= fatal_d;
    end
  end

  always_comb begin
    stage_count = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      stage_count[i*TIMER_W +: TIMER_W] = count_q[i];
    end
  end

  assign stage_expired = expired_q;
  assign stage_timeout = timeout_q;
  assign wdt_fatal     = fatal_q;

endmodule

// File: tb/tb_mci_wdt_chain.sv
module tb_mci_wdt_chain;
  localparam int NS = 2;
  localparam int TW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NS-1:0]    stage_en, stage_restart;
  logic             cascade_mode;
  logic             wdt_pause;
  logic [NS*TW-1:0] timeout_period;
  logic [NS*TW-1:0] stage_count;
  logic [NS-1:0]    stage_expired, stage_timeout;
  logic             wdt_fatal;

  int unsigned per [NS];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always_comb begin
    timeout_period = '0;
    for (int i = 0; i < NS; i++) timeout_period[i*TW +: TW] = TW'(per[i]);
  end

  mci_wdt_chain #(.NUM_STAGES(NS), .TIMER_W(TW)) dut (
    .clk(clk),
    .rst(rst),
    .stage_en(stage_en),
    .stage_restart(stage_restart),
    .cascade_mode(cascade_mode),
`ifdef MCI_WDT_PAUSE_EN
    .wdt_pause(wdt_pause),
`endif
    .timeout_period(timeout_period),
    .stage_count(stage_count),
    .stage_expired(stage_expired),
    .stage_timeout(stage_timeout),
    .wdt_fatal(wdt_fatal)
  );

  // Reference model: one integer counter per stage plus status flags.
  longint unsigned m_cnt [NS];
  bit              m_exp [NS];
  bit              m_to  [NS];
  bit              m_fatal;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit old_exp [NS];
    int first_rs;
    bit paused;
`ifdef MCI_WDT_PAUSE_EN
    paused = wdt_pause;
`else
    paused = 1'b0;
`endif
    if (rst) begin
      for (int i = 0; i < NS; i++) begin
        m_cnt[i] = 0; m_exp[i] = 0; m_to[i] = 0;
      end
      m_fatal = 0;
      return;
    end
    old_exp  = m_exp;
    first_rs = NS;
    for (int i = NS - 1; i >= 0; i--) if (stage_restart[i]) first_rs = i;
    for (int i = 0; i < NS; i++) begin
      bit wipe, active;
      wipe   = stage_restart[i] || (cascade_mode && first_rs < i);
      active = stage_en[i] && !old_exp[i] && !paused &&
               !(cascade_mode && i > 0 && !old_exp[(i > 0) ? i-1 : 0]);
      m_to[i] = 0;
      if (wipe) begin
        m_cnt[i] = 0; m_exp[i] = 0;
      end else if (active) begin
        if (m_cnt[i] >= per[i]) begin
          m_exp[i] = 1; m_to[i] = 1;
          if (i == NS - 1 && cascade_mode) m_fatal = 1;
        end else begin
          m_cnt[i]++;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [63:0] ec, ee, et;
    ec = '0; ee = '0; et = '0;
    for (int i = 0; i < NS; i++) begin
      ec[i*TW +: TW] = TW'(m_cnt[i]);
      ee[i] = m_exp[i];
      et[i] = m_to[i];
    end
    check_eq("count",   64'(stage_count),   ec);
    check_eq("expired", 64'(stage_expired), ee);
    check_eq("timeout", 64'(stage_timeout), et);
    check_eq("fatal",   64'(wdt_fatal),     64'(m_fatal));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1; stage_restart = '0; stage_en = '0; wdt_pause = 0;
    tick();
    rst = 0;
  endtask

  initial begin
    rst = 1; stage_en = '0; stage_restart = '0; cascade_mode = 0; wdt_pause = 0;
    per[0] = 0; per[1] = 0;
    do_reset();
    check_eq("rst_count", 64'(stage_count), 64'd0);
    check_eq("rst_fatal", 64'(wdt_fatal), 64'd0);

    // Independent mode: P0=5 and P1=9.
    cascade_mode = 0; per[0] = 5; per[1] = 9; stage_en = 2'b11;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 6)  check_eq("ind_to0", 64'(stage_timeout), 64'b01);
      if (k == 10) check_eq("ind_to1", 64'(stage_timeout), 64'b10);
    end
    check_eq("ind_fatal", 64'(wdt_fatal), 64'd0);

    // Cascade mode: P0=3 and P1=4.
    do_reset();
    cascade_mode = 1; per[0] = 3; per[1] = 4; stage_en = 2'b11;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 4) check_eq("cas_to0", 64'(stage_timeout), 64'b01);
      if (k == 9) begin
        check_eq("cas_to1",   64'(stage_timeout), 64'b10);
        check_eq("cas_fatal", 64'(wdt_fatal),     64'd1);
      end
    end
    stage_restart = 2'b01; tick(); stage_restart = '0;
    check_eq("cas_rs_exp",   64'(stage_expired), 64'd0);
    check_eq("cas_rs_fatal", 64'(wdt_fatal),     64'd1);

    // A restart on the expiry edge wins over the expiry.
    do_reset();
    cascade_mode = 1; per[0] = 3; per[1] = 5; stage_en = 2'b11;
    repeat (3) tick();
    stage_restart = 2'b01; tick(); stage_restart = '0;
    check_eq("rw_to",  64'(stage_timeout), 64'd0);
    check_eq("rw_cnt", 64'(stage_count),   64'd0);
    tick();
    check_eq("rw_cnt1", 64'(stage_count[TW +: TW]), 64'd0);

    // Lowering the period below the current count.
    do_reset();
    cascade_mode = 0; per[0] = 100; per[1] = 0; stage_en = 2'b01;
    repeat (20) tick();
    per[0] = 10; tick();
    check_eq("pl_to", 64'(stage_timeout), 64'b01);
    tick();
    check_eq("pl_to_once", 64'(stage_timeout), 64'd0);

    // Dropping the enable pauses the count without clearing it.
    do_reset();
    per[0] = 12; stage_en = 2'b01;
    repeat (7) tick();
    stage_en = '0;
    repeat (50) tick();
    check_eq("en_hold", 64'(stage_count[0 +: TW]), 64'd7);
    stage_en = 2'b01;
    repeat (5) tick();
    check_eq("en_no_to", 64'(stage_timeout), 64'd0);
    tick();
    check_eq("en_to", 64'(stage_timeout), 64'b01);

`ifdef MCI_WDT_PAUSE_EN
    // A pause held across the would-be expiry edge delays the expiry.
    do_reset();
    per[0] = 4; stage_en = 2'b01;
    repeat (4) tick();
    wdt_pause = 1;
    repeat (3) tick();
    check_eq("pz_to", 64'(stage_timeout), 64'd0);
    wdt_pause = 0; tick();
    check_eq("pz_rel", 64'(stage_timeout), 64'b01);
`endif

    // Asserting rst mid-count returns every output to zero.
    do_reset();
    per[0] = 50; per[1] = 50; stage_en = 2'b11;
    repeat (8) tick();
    rst = 1; stage_restart = 2'b10; tick(); rst = 0; stage_restart = '0;
    check_eq("mrst_cnt", 64'(stage_count),   64'd0);
    check_eq("mrst_exp", 64'(stage_expired), 64'd0);

    // Randomized stimulus.
    do_reset();
    per[0] = 3; per[1] = 5; cascade_mode = 1;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NS; i++) begin
        stage_en[i]      = ($urandom_range(7) != 0);
        stage_restart[i] = ($urandom_range(15) == 0);
        if ($urandom_range(31) == 0) per[i] = $urandom_range(12);
      end
      if ($urandom_range(63) == 0) cascade_mode = ~cascade_mode;
      rst = ($urandom_range(199) == 0);
`ifdef MCI_WDT_PAUSE_EN
      wdt_pause = ($urandom_range(7) == 0);
`endif
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
